dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 m0_req, m1_req  input  1 each  requester n wants one memory transaction.
REQ-005 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  input  32 each  byte address.
REQ-007 m0_wdata, m1_wdata  input  32 each  write data.
REQ-008 m0_ack, m1_ack  output  1 each  one-cycle transaction-complete pulse.
REQ-009 m0_rdata, m1_rdata  output  32 each  read data, valid while the matching ack is high.
REQ-010 mem_wen, mem_ren  output  1 each  data-memory write and read enables.
REQ-011 mem_addr  output  32  data-memory address.
REQ-012 mem_data_i  output  32  write data into the data memory.
REQ-013 mem_data_o  input  32  combinational read data from the data memory.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, RESP; the transitions SHALL be IDLE->BUSY on any req, BUSY->RESP always, RESP->IDLE always.
REQ-015 In IDLE, on a rising edge with any req high, the block SHALL select a winner and register its we/addr/wdata and the winner index.
REQ-016 In BUSY, the block SHALL drive mem_addr from the registered address with bits [1:0] forced to 0.
REQ-017 In BUSY, a registered write SHALL drive mem_wen=1, mem_ren=0 and mem_data_i=registered wdata.
REQ-018 In BUSY, a registered read SHALL drive mem_ren=1 and mem_wen=0.
REQ-019 All of these memory outputs SHALL be registered and stable for the whole BUSY cycle, because the memory writes on the falling edge.
REQ-020 Outside BUSY, mem_wen=0, mem_ren=0, mem_addr=0 and mem_data_i=0.
REQ-021 At the BUSY->RESP edge, the block SHALL capture mem_data_o into the winner's rdata register when the transaction is a read; a write SHALL leave rdata unchanged.
REQ-022 In RESP, the winner's ack SHALL be 1 for exactly one cycle, and the other ack SHALL be 0.
REQ-023 Latency SHALL be: req sampled at edge k, BUSY during cycle k..k+1, ack high during cycle k+1..k+2.
REQ-024 Throughput SHALL be one transaction per 3 cycles.
REQ-025 A requester SHALL hold req, we, addr and wdata stable until it samples ack; the arbiter ignores changes to these fields after they are captured.
REQ-026 Requests are not sampled in RESP, so a req still high during ack is not double-granted; a req still high at the RESP->IDLE edge is granted again at the next IDLE edge.
REQ-027 A losing requester SHALL stay pending with no ack until it is granted.

Reset
REQ-028 While rst is high at a rising edge, the block SHALL set: state=IDLE, acks=0, rdata=0, all mem_* outputs=0, last-grant pointer=1.
REQ-029 Reset asserted during BUSY SHALL abort with no ack issued; a falling-edge write already performed in that BUSY cycle is not undone.
REQ-030 Reset asserted during RESP SHALL clear the ack at that edge.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN, when defined, SHALL enable round-robin: on a simultaneous request the block grants the index other than the last-granted one, and the pointer updates on each grant.
REQ-032 When DMEM_ARB_RR_EN is not defined, the block SHALL use fixed priority (m0 always wins) and SHALL remove the pointer register.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold: the state enum (IDLE, BUSY, RESP), the requester index constants M0=0 and M1=1, and the widths ADDR_W=32 and DATA_W=32.
REQ-034 Winner selection SHALL be a sub-module dmem_arb_pick (inputs: two reqs and the pointer; output: grant index); everything else stays in dmem_arbiter.

Verification
REQ-035 m0 write addr=0x10, wdata=0xDEADBEEF, then m0 read addr=0x10 -> one BUSY cycle with mem_wen=1 and mem_addr=0x10; the read then gives m0_rdata=0xDEADBEEF with m0_ack high for one cycle, 2 cycles after the req edge.
REQ-036 Both request at the same edge after reset -> m0 granted first; with DMEM_ARB_RR_EN m1 is granted next, and with the second simultaneous pair m0 wins again; without the macro m0 wins whenever both request.
REQ-037 m1 read addr=0x13 -> mem_addr=0x10; m1 read data equals the word stored at 0x10.
REQ-038 Both reqs held continuously for 12 cycles, DMEM_ARB_RR_EN defined -> acks alternate m0, m1, m0, m1 every 3 cycles; no ack is ever given to both at once.
REQ-039 rst pulsed in BUSY of an m1 read -> no m1_ack; next cycle all mem_* outputs are 0 and state=IDLE; a following m0 request completes normally.
REQ-040 req held high through the ack cycle -> exactly one ack per 3 cycles; mem_wen is never high outside BUSY.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the two-master data-memory arbiter.
//   state_t      : arbiter FSM states (IDLE, BUSY, RESP)
//   M0 / M1      : requester index constants used as the grant encoding
//   ADDR_W/DATA_W: address and data widths
//   word_align() : clears the byte-offset bits of an address
package dmem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // The data memory is word addressed; bits [1:0] are masked rather than sliced
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & {{(ADDR_W-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection between two requesters.
//   req0, req1 : request lines of requester 0 and 1
//   last       : index of the most recently granted requester
//   grant      : index of the winner (meaningful only when a req is high)
// On a tie the requester other than 'last' wins. Tying 'last' to M1
// therefore gives fixed priority to M0.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant
);

   // Tie goes to the requester that did not win last time
   always_comb begin
      grant = M0;
      if (req0 && req1) begin
         grant = ~last;
      end else if (req1) begin
         grant = M1;
      end else begin
         grant = M0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two masters onto one single-port data memory.
// Each transaction takes three cycles: IDLE (grant), BUSY (memory access),
// RESP (one-cycle ack to the winner).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   mN_req/we/addr/wdata (N=0,1) : request, 1=write, byte address, write data
//   mN_ack, mN_rdata             : completion pulse, read data (valid with ack)
//   mem_wen, mem_ren, mem_addr   : registered memory controls, non-zero only in BUSY
//   mem_data_i                   : registered write data into memory
//   mem_data_o                   : combinational read data from memory
// Configuration: define DMEM_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise m0 has fixed priority and no pointer register exists.
module dmem_arbiter
   import dmem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_i,
   input  logic [DATA_W-1:0] mem_data_o
);

   state_t            state_r, state_nxt_s;
   logic              win_r, win_nxt_s;
   logic              mem_wen_r, mem_wen_nxt_s;
   logic              mem_ren_r, mem_ren_nxt_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
   logic [DATA_W-1:0] mem_data_i_r, mem_data_i_nxt_s;
   logic              ack0_r, ack0_nxt_s;
   logic              ack1_r, ack1_nxt_s;
   logic [DATA_W-1:0] rdata0_r, rdata0_nxt_s;
   logic [DATA_W-1:0] rdata1_r, rdata1_nxt_s;

   logic              any_req_s;
   logic              grant_s;
   logic              last_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

   assign any_req_s = m0_req | m1_req;

`ifdef DMEM_ARB_RR_EN
   logic ptr_r;

   // Last-grant pointer, updated on every grant
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= M1;
      end else if ((state_r == IDLE) && any_req_s) begin
         ptr_r <= grant_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign last_s = ptr_r;
`else
   assign last_s = M1;
`endif

   dmem_arb_pick u_pick (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (last_s),
      .grant (grant_s)
   );

   // Fields of the selected requester
   always_comb begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      if (grant_s == M1) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_nxt_s      = state_r;
      win_nxt_s        = win_r;
      mem_wen_nxt_s    = 1'b0;
      mem_ren_nxt_s    = 1'b0;
      mem_addr_nxt_s   = {ADDR_W{1'b0}};
      mem_data_i_nxt_s = {DATA_W{1'b0}};
      ack0_nxt_s       = 1'b0;
      ack1_nxt_s       = 1'b0;
      rdata0_nxt_s     = rdata0_r;
      rdata1_nxt_s     = rdata1_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               // Memory controls are loaded here so they are stable for all of BUSY
               state_nxt_s    = BUSY;
               win_nxt_s      = grant_s;
               mem_wen_nxt_s  = sel_we_s;
               mem_ren_nxt_s  = ~sel_we_s;
               mem_addr_nxt_s = word_align(sel_addr_s);
               if (sel_we_s) begin
                  mem_data_i_nxt_s = sel_wdata_s;
               end else begin
                  mem_data_i_nxt_s = {DATA_W{1'b0}};
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            state_nxt_s = RESP;
            if (win_r == M1) begin
               ack1_nxt_s = 1'b1;
               if (mem_ren_r) begin
                  rdata1_nxt_s = mem_data_o;
               end else begin
                  rdata1_nxt_s = rdata1_r;
               end
            end else begin
               ack0_nxt_s = 1'b1;
               if (mem_ren_r) begin
                  rdata0_nxt_s = mem_data_o;
               end else begin
                  rdata0_nxt_s = rdata0_r;
               end
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         win_r        <= M0;
         mem_wen_r    <= 1'b0;
         mem_ren_r    <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_data_i_r <= {DATA_W{1'b0}};
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         rdata0_r     <= {DATA_W{1'b0}};
         rdata1_r     <= {DATA_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         win_r        <= win_nxt_s;
         mem_wen_r    <= mem_wen_nxt_s;
         mem_ren_r    <= mem_ren_nxt_s;
         mem_addr_r   <= mem_addr_nxt_s;
         mem_data_i_r <= mem_data_i_nxt_s;
         ack0_r       <= ack0_nxt_s;
         ack1_r       <= ack1_nxt_s;
         rdata0_r     <= rdata0_nxt_s;
         rdata1_r     <= rdata1_nxt_s;
      end
   end

   assign m0_ack     = ack0_r;
   assign m1_ack     = ack1_r;
   assign m0_rdata   = rdata0_r;
   assign m1_rdata   = rdata1_r;
   assign mem_wen    = mem_wen_r;
   assign mem_ren    = mem_ren_r;
   assign mem_addr   = mem_addr_r;
   assign mem_data_i = mem_data_i_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against dmem_arbiter with a
// transaction-level reference model (grant time, winner, golden memory)
// checked every cycle, plus hand-computed literal expectations.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
   logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_wen, mem_ren;
   logic [31:0] mem_addr, mem_data_i, mem_data_o;

   int errors = 0;
   int checks = 0;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
      .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Data memory seen by the DUT: combinational read, write on falling edge
   logic [31:0] dut_mem [0:63];
   bit          mem_init = 1'b0;
   assign mem_data_o = dut_mem[mem_addr[7:2]];

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) dut_mem[i] <= 32'hA5A5_0000 + i;
         mem_init <= 1'b1;
      end else if (mem_wen === 1'b1) begin
         dut_mem[mem_addr[7:2]] <= mem_data_i;
      end
   end

   // Reference model: one transaction at a time, granted at edge t_start,
   // memory access in the cycle after, ack in the cycle after that,
   // next grant possible three edges after t_start.
   int          edge_n = 0;
   bit          t_valid = 1'b0;
   int          t_start = 0;
   int          next_free = 0;
   logic        t_win = 1'b0, t_we = 1'b0;
   logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
   logic        last_g = 1'b1;
   logic [31:0] exp_rd [0:1];
   logic [31:0] golden [0:63];

   always @(posedge clk) begin
      int   e;
      logic w;
      e = edge_n + 1;
      edge_n <= e;
      if (e == 1) begin
         for (int i = 0; i < 64; i++) golden[i] <= 32'hA5A5_0000 + i;
      end
      if (rst) begin
         t_valid   <= 1'b0;
         next_free <= e + 1;
         last_g    <= 1'b1;
         exp_rd[0] <= 32'h0;
         exp_rd[1] <= 32'h0;
      end else begin
         if (t_valid && (e == t_start + 1) && !t_we) exp_rd[t_win] <= golden[t_addr[7:2]];
         if ((e >= next_free) && (m0_req || m1_req)) begin
`ifdef DMEM_ARB_RR_EN
            if (m0_req && m1_req) w = !last_g; else w = m1_req;
`else
            w = !m0_req;
`endif
            t_valid   <= 1'b1;
            t_start   <= e;
            next_free <= e + 3;
            t_win     <= w;
            last_g    <= w;
            t_we      <= w ? m1_we : m0_we;
            t_addr    <= w ? m1_addr : m0_addr;
            t_wdata   <= w ? m1_wdata : m0_wdata;
            if (w ? m1_we : m0_we) golden[(w ? m1_addr[7:2] : m0_addr[7:2])] <= (w ? m1_wdata : m0_wdata);
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      int          age;
      logic        e_wen, e_ren, e_ack0, e_ack1;
      logic [31:0] e_addr, e_data;
      if (edge_n > 0) begin
         age = edge_n - t_start;
         e_wen = 1'b0; e_ren = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
         e_addr = 32'h0; e_data = 32'h0;
         if (t_valid && age == 0) begin
            e_wen  = t_we;
            e_ren  = !t_we;
            e_addr = {t_addr[31:2], 2'b00};
            e_data = t_we ? t_wdata : 32'h0;
         end
         if (t_valid && age == 1) begin
            e_ack0 = (t_win == 1'b0);
            e_ack1 = (t_win == 1'b1);
         end
         chk("mdl_m0_ack", m0_ack, e_ack0);
         chk("mdl_m1_ack", m1_ack, e_ack1);
         chk("mdl_mem_wen", mem_wen, e_wen);
         chk("mdl_mem_ren", mem_ren, e_ren);
         chk("mdl_mem_addr", mem_addr, e_addr);
         chk("mdl_mem_data_i", mem_data_i, e_data);
         if (e_ack0) chk("mdl_m0_rdata", m0_rdata, exp_rd[0]);
         if (e_ack1) chk("mdl_m1_rdata", m1_rdata, exp_rd[1]);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   // One transaction from one requester; req dropped in the ack cycle
   task automatic single(input logic who, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                         output logic [31:0] b_addr, output logic b_wen);
      lat = -1; rd = 32'h0; b_addr = 32'h0; b_wen = 1'b0;
      if (who) begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk); #1;
         if (i == 1) begin
            b_addr = mem_addr; b_wen = mem_wen;
         end
         if ((who ? m1_ack : m0_ack) === 1'b1) begin
            lat = i;
            rd = who ? m1_rdata : m0_rdata;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   // Both requesters read; record the order of acks
   task automatic run_both(input bit drop, input int maxc, input int want,
                           output logic [3:0] order, output int n);
      order = 4'b0000; n = 0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
      for (int i = 0; i < maxc && n < want; i++) begin
         @(negedge clk); #1;
         if (m0_ack === 1'b1 && n < 4) begin
            order[n] = 1'b0; n++;
            if (drop) m0_req = 1'b0;
         end
         if (m1_ack === 1'b1 && n < 4) begin
            order[n] = 1'b1; n++;
            if (drop) m1_req = 1'b0;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int          lat, n, acks;
      logic [31:0] rd, b_addr;
      logic        b_wen;
      logic [3:0]  order;

      rst = 1'b1;
      idle(3);
      chk("rst_m0_ack", m0_ack, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wen", mem_wen, 32'h0);
      rst = 1'b0;
      idle(1);

      // Write then read back through m0
      single(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, b_addr, b_wen);
      chk("wr_busy_wen", b_wen, 32'h1);
      chk("wr_busy_addr", b_addr, 32'h10);
      chk("wr_latency", lat, 32'd2);
      idle(1);
      single(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, b_addr, b_wen);
      chk("rd_latency", lat, 32'd2);
      chk("rd_m0_rdata", rd, 32'hDEADBEEF);
      idle(1);

      // Unaligned m1 read
      single(1'b1, 1'b0, 32'h13, 32'h0, lat, rd, b_addr, b_wen);
      chk("unal_mem_addr", b_addr, 32'h10);
      chk("unal_m1_rdata", rd, 32'hDEADBEEF);
      idle(1);

      // Simultaneous requests after reset, twice
      rst = 1'b1; idle(1); rst = 1'b0; idle(1);
      run_both(1'b1, 12, 2, order, n);
      chk("tie1_count", n, 32'd2);
      chk("tie1_order", {28'h0, order}, 32'h2);
      idle(2);
      run_both(1'b1, 12, 2, order, n);
      chk("tie2_count", n, 32'd2);
      chk("tie2_order", {28'h0, order}, 32'h2);
      idle(2);

      // Both held for 12 cycles
      run_both(1'b0, 12, 4, order, n);
      chk("hold_count", n, 32'd4);
`ifdef DMEM_ARB_RR_EN
      chk("hold_order", {28'h0, order}, 32'hA);
`else
      chk("hold_order", {28'h0, order}, 32'h0);
`endif
      idle(3);

      // Reset during BUSY of an m1 read
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
      idle(1);
      chk("abort_busy_ren", mem_ren, 32'h1);
      rst = 1'b1; m1_req = 1'b0;
      idle(1);
      chk("abort_m1_ack", m1_ack, 32'h0);
      chk("abort_mem_ren", mem_ren, 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (m1_ack === 1'b1) acks++;
      end
      chk("abort_no_ack", acks, 32'd0);
      single(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, b_addr, b_wen);
      chk("after_abort_lat", lat, 32'd2);
      chk("after_abort_rdata", rd, 32'hDEADBEEF);
      idle(1);

      // Reset during RESP clears the ack
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      idle(2);
      chk("resp_ack_seen", m0_ack, 32'h1);
      rst = 1'b1; m0_req = 1'b0;
      idle(1);
      chk("resp_ack_cleared", m0_ack, 32'h0);
      rst = 1'b0;
      idle(1);

      // m0 write held high through ack: one ack per 3 cycles
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h12345678;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (m0_ack === 1'b1) acks++;
      end
      m0_req = 1'b0; m0_we = 1'b0;
      chk("held_ack_count", acks, 32'd4);
      idle(3);
      single(1'b1, 1'b0, 32'h20, 32'h0, lat, rd, b_addr, b_wen);
      chk("held_readback", rd, 32'h12345678);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
